// File: rtl/adder_pkg.sv
// Shared constants for the accumulator slice:
// datapath widths and FSM state encoding.
package adder_pkg;

  localparam int WIDTH   = 16;
  localparam int COUNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/acc_16_if.sv
// Operand stream in, frame result out,
// both under valid/ready handshakes.
interface acc_16_if
  import adder_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int CW = COUNT_W
) ();

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sum,
    input  out_carry, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_sum,
    output out_carry, out_count
  );

endinterface

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder: four 4-bit
// groups with group generate/propagate.
module CLA_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cr
);

  logic [15:0] g;
  logic [15:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // group carries skip across each nibble
  always_comb begin : cla
    logic carry;
    logic cc;
    logic gg;
    logic gp;
    sum   = '0;
    carry = cin;
    for (int k = 0; k < 4; k++) begin
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2]
            & p[4*k+1] & g[4*k]);
      gp = p[4*k+3] & p[4*k+2]
         & p[4*k+1] & p[4*k];
      cc = carry;
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ cc;
        cc = g[4*k+j] | (p[4*k+j] & cc);
      end
      carry = gg | (gp & carry);
    end
    cr = carry;
  end

endmodule

// File: rtl/acc_16.sv
// Frame accumulator: sums beats through
// CLA_16, emits sum/sticky carry/count.
module acc_16
  import adder_pkg::*;
(
  input logic     clk,
  input logic     rst,
  acc_16_if.slave s
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] cla_sum;
  logic             cla_cr;
  logic             accept;
  logic             drain;

  CLA_16 u_cla (
    .a   (acc_q),
    .b   (s.in_data),
    .cin (1'b0),
    .sum (cla_sum),
    .cr  (cla_cr)
  );

  assign s.in_ready  = (state_q != ST_DONE)
                     && !rst;
  assign accept      = s.in_valid
                     && s.in_ready;
  assign drain       = (state_q == ST_DONE)
                     && s.out_ready;

  assign s.out_valid = (state_q == ST_DONE);
  assign s.out_sum   = acc_q;
  assign s.out_carry = carry_q;
  assign s.out_count = count_q;

  // next-state: accumulate, finish, drain
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    unique case (1'b1)
      accept: begin
        acc_d   = cla_sum;
        carry_d = carry_q | cla_cr;
        if (count_q != '1)
          count_d = count_q + COUNT_W'(1);
        state_d = s.in_last ? ST_DONE
                            : ST_ACC;
      end
      drain: begin
        acc_d   = '0;
        carry_d = 1'b0;
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_acc_16.sv
// Directed bench for acc_16 with a
// frame-level reference model.
module tb_acc_16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  acc_16_if bus ();

  acc_16 u_dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  int m_sum   = 0;
  bit m_carry = 0;
  int m_count = 0;
  bit m_done  = 0;
  bit started = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // frame model: plain integer arithmetic
  always @(posedge clk) begin
    int t;
    started = 1;
    if (rst) begin
      m_sum = 0; m_carry = 0;
      m_count = 0; m_done = 0;
    end else if (m_done) begin
      if (bus.out_ready) begin
        m_sum = 0; m_carry = 0;
        m_count = 0; m_done = 0;
      end
    end else if (bus.in_valid) begin
      t = m_sum + int'(bus.in_data);
      if (t > 65535) m_carry = 1;
      m_sum = t % 65536;
      if (m_count < 255) m_count++;
      if (bus.in_last) m_done = 1;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready",
          32'(bus.in_ready),
          32'(!rst && !m_done));
      chk("m_out_valid",
          32'(bus.out_valid),
          32'(m_done));
      if (m_done) begin
        chk("m_sum", 32'(bus.out_sum),
            32'(m_sum));
        chk("m_carry", 32'(bus.out_carry),
            32'(m_carry));
        chk("m_count", 32'(bus.out_count),
            32'(m_count));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [15:0] d,
    input logic        last
  );
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    sync();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_res(
    input string       nm,
    input logic [15:0] sum,
    input logic        cy,
    input logic [7:0]  cnt
  );
    @(negedge clk);
    chk({nm, "_valid"},
        32'(bus.out_valid), 32'd1);
    chk({nm, "_sum"},
        32'(bus.out_sum), 32'(sum));
    chk({nm, "_carry"},
        32'(bus.out_carry), 32'(cy));
    chk({nm, "_count"},
        32'(bus.out_count), 32'(cnt));
  endtask

  task automatic post(input string nm);
    sync();
    @(negedge clk);
    chk({nm, "_ready_after"},
        32'(bus.in_ready), 32'd1);
    sync();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hABCD;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.out_sum), 0);
    chk("rst_count", 32'(bus.out_count), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    sync();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(bus.in_ready), 1);
    chk("rel_valid", 32'(bus.out_valid), 0);
    sync();

    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b1);
    expect_res("basic", 16'h0006, 0, 8'd3);
    post("basic");

    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
    expect_res("carry", 16'h0001, 1, 8'd2);
    post("carry");
    send(16'h0005, 1'b1);
    expect_res("clr", 16'h0005, 0, 8'd1);
    post("clr");

    send(16'h0010, 1'b0);
    sync();
    sync();
    bus.out_ready = 1'b0;
    send(16'h0020, 1'b1);
    expect_res("gap", 16'h0030, 0, 8'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0100;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sync();
      @(negedge clk);
      chk("bp_valid",
          32'(bus.out_valid), 1);
      chk("bp_sum",
          32'(bus.out_sum), 32'h30);
      chk("bp_count",
          32'(bus.out_count), 2);
      chk("bp_ready",
          32'(bus.in_ready), 0);
    end
    sync();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    sync();
    @(negedge clk);
    chk("drain_valid",
        32'(bus.out_valid), 0);
    chk("drain_sum", 32'(bus.out_sum), 0);
    sync();

    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    send(16'h0007, 1'b1);
    expect_res("midrst", 16'h0007, 0, 8'd1);
    post("midrst");

    for (int i = 0; i < 299; i++)
      send(16'h0001, 1'b0);
    send(16'h0001, 1'b1);
    expect_res("sat", 16'h012C, 0, 8'd255);
    post("sat");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
